pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the CGRA control path. Owns the PC register, a vector-element counter and a hardware loop stack. Advances, branches, loops or stalls on the current instruction's decode flags and the datapath steady-state handshake. Sits between the instruction memory (drives its address) and the decode/datapath stage (consumes its flags).

---
 rtl/pc_sequencer_pkg.sv | 38 +++
 rtl/pc_sequencer_if.sv | 43 ++++
 rtl/pc_sequencer_loop_stack.sv | 46 ++++
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 tb/tb_pc_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and helpers for the CGRA program-counter sequencer
package cgra_pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_VECT = 2'd2,
    ST_HALT = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BNE  = 2'd1,
    BR_BEQ  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  // Stack entries are sized for the widest supported PC / loop count; the
  // sequencer zero-extends on push and truncates on use.
  localparam int ENTRY_W = 32;

  typedef struct packed {
    logic [ENTRY_W-1:0] addr;
    logic [ENTRY_W-1:0] count;
  } loop_entry_t;

  function automatic logic branch_taken(input br_type_e br, input logic flag_neq);
    logic taken;
    case (br)
      BR_BNE:  taken = flag_neq;
      BR_BEQ:  taken = !flag_neq;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode/datapath handshake bundle for the PC sequencer
interface pc_sequencer_if #(
  parameter int PC_W   = 12,
  parameter int VLEN_W = 16,
  parameter int LCNT_W = 16
);
  logic              start;
  logic [PC_W-1:0]   start_pc;
  logic              done_steady;
  logic              is_not_vect;
  logic              is_vstreamout;
  logic              supplier;
  logic [VLEN_W-1:0] vec_len;
  logic [1:0]        br_type;
  logic              flag_neq;
  logic [PC_W-1:0]   br_target;
  logic              is_loop;
  logic [LCNT_W-1:0] loop_count;
  logic              is_endloop;
  logic              is_halt;
  logic [PC_W-1:0]   pc;
  logic [VLEN_W-1:0] vec_idx;
  logic              retire;
  logic              busy;
  logic              halted;
  logic              stack_err;

  // Decode / control side: supplies instruction flags, observes the PC.
  modport master (
    output start, start_pc, done_steady, is_not_vect, is_vstreamout, supplier,
           vec_len, br_type, flag_neq, br_target, is_loop, loop_count,
           is_endloop, is_halt,
    input  pc, vec_idx, retire, busy, halted, stack_err
  );

  // Sequencer side.
  modport slave (
    input  start, start_pc, done_steady, is_not_vect, is_vstreamout, supplier,
           vec_len, br_type, flag_neq, br_target, is_loop, loop_count,
           is_endloop, is_halt,
    output pc, vec_idx, retire, busy, halted, stack_err
  );
endinterface

// File: rtl/pc_sequencer_loop_stack.sv
// rtl/pc_sequencer_loop_stack.sv - hardware loop stack of {return addr, remaining count}
module pc_loop_stack
  import cgra_pc_pkg::*;
#(
  parameter int LOOP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic        dec_top,
  input  loop_entry_t push_entry,
  output loop_entry_t top,
  output logic        full,
  output logic        empty
);
  localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  loop_entry_t       mem_q [LOOP_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;

  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign push_idx = IDX_W'(sp_q);
  assign full     = (sp_q == SP_W'(LOOP_DEPTH));
  assign empty    = (sp_q == '0);
  assign top      = empty ? '0 : mem_q[top_idx];

  // Stack pointer and entry storage; only one operation is honoured per cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sp_q <= '0;
    end else if (push && !full) begin
      mem_q[push_idx] <= push_entry;
      sp_q            <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SP_W'(1);
    end else if (dec_top && !empty) begin
      mem_q[top_idx].count <= mem_q[top_idx].count - ENTRY_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - CGRA program-counter sequencer with vector and loop control
module pc_sequencer
  import cgra_pc_pkg::*;
#(
  parameter int PC_W       = 12,
  parameter int VLEN_W     = 16,
  parameter int LOOP_DEPTH = 4,
  parameter int LCNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  pc_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [VLEN_W-1:0] vec_idx_q, vec_idx_d;
  logic              stack_err_q, stack_err_d;
  logic              busy_q, halted_q;
  logic              retire;

  logic              stk_push, stk_pop, stk_dec, stk_clear;
  logic              stk_full, stk_empty;
  loop_entry_t       stk_top, stk_push_entry;

  logic [PC_W-1:0]   pc_inc;
  logic              vect_retire;
  logic              vect_last;
  logic              unused_addr_hi;

  assign pc_inc      = pc_q + PC_W'(1);
  assign vect_retire = bus.done_steady && (!bus.is_vstreamout || bus.supplier);
  // A zero-length vector still occupies one element slot.
  assign vect_last   = (bus.vec_len == '0) ? (vec_idx_q == '0)
                                           : (vec_idx_q == bus.vec_len - VLEN_W'(1));

  // The body restarts at the instruction after the loop-begin; the stored
  // count is the number of further passes still owed.
  assign stk_push_entry = '{addr:  ENTRY_W'(pc_inc),
                            count: ENTRY_W'(bus.loop_count - LCNT_W'(1))};

  // Entry address bits above PC_W are always written as zero.
  assign unused_addr_hi = ^(stk_top.addr >> PC_W);

  pc_loop_stack #(
    .LOOP_DEPTH (LOOP_DEPTH)
  ) u_loop_stack (
    .clk        (clk),
    .rst        (rst),
    .clear      (stk_clear),
    .push       (stk_push),
    .pop        (stk_pop),
    .dec_top    (stk_dec),
    .push_entry (stk_push_entry),
    .top        (stk_top),
    .full       (stk_full),
    .empty      (stk_empty)
  );

  // Next-state, retire and loop-stack control from the current instruction flags.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    vec_idx_d   = vec_idx_q;
    stack_err_d = stack_err_q;
    retire      = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_dec     = 1'b0;
    stk_clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          pc_d      = bus.start_pc;
          state_d   = ST_RUN;
          stk_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.done_steady) begin
          retire = 1'b1;
          if (bus.is_halt) begin
            state_d = ST_HALT;
          end else if (!bus.is_not_vect) begin
            state_d   = ST_VECT;
            vec_idx_d = '0;
          end else if (bus.is_endloop) begin
            if (stk_empty) begin
              stack_err_d = 1'b1;
              pc_d        = pc_inc;
            end else if (stk_top.count != '0) begin
              stk_dec = 1'b1;
              pc_d    = PC_W'(stk_top.addr);
            end else begin
              stk_pop = 1'b1;
              pc_d    = pc_inc;
            end
          end else if (bus.is_loop) begin
            if (bus.loop_count == '0) begin
              pc_d = bus.br_target;
            end else if (stk_full) begin
              stack_err_d = 1'b1;
              pc_d        = pc_inc;
            end else begin
              stk_push = 1'b1;
              pc_d     = pc_inc;
            end
          end else if (branch_taken(br_type_e'(bus.br_type), bus.flag_neq)) begin
            pc_d = bus.br_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_VECT: begin
        if (vect_retire) begin
          retire = 1'b1;
          if (vect_last) begin
            vec_idx_d = '0;
            pc_d      = pc_inc;
            state_d   = ST_RUN;
          end else begin
            vec_idx_d = vec_idx_q + VLEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      vec_idx_q   <= '0;
      stack_err_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      vec_idx_q   <= vec_idx_d;
      stack_err_q <= stack_err_d;
      busy_q      <= (state_d == ST_RUN) || (state_d == ST_VECT);
      halted_q    <= (state_d == ST_HALT);
    end
  end

  assign bus.pc        = pc_q;
  assign bus.vec_idx   = vec_idx_q;
  assign bus.retire    = retire;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.stack_err = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(12), .VLEN_W(16), .LCNT_W(16)) bus ();

  pc_sequencer #(
    .PC_W       (12),
    .VLEN_W     (16),
    .LOOP_DEPTH (4),
    .LCNT_W     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start         = 1'b0;
    bus.start_pc      = '0;
    bus.done_steady   = 1'b0;
    bus.is_not_vect   = 1'b1;
    bus.is_vstreamout = 1'b0;
    bus.supplier      = 1'b0;
    bus.vec_len       = '0;
    bus.br_type       = 2'd0;
    bus.flag_neq      = 1'b0;
    bus.br_target     = '0;
    bus.is_loop       = 1'b0;
    bus.loop_count    = '0;
    bus.is_endloop    = 1'b0;
    bus.is_halt       = 1'b0;
  endtask

  task automatic jump_to(input logic [11:0] tgt);
    idle_in();
    bus.done_steady = 1'b1;
    bus.br_type     = 2'd3;
    bus.br_target   = tgt;
    step();
    idle_in();
  endtask

  task automatic scalar_step();
    idle_in();
    bus.done_steady = 1'b1;
    step();
    idle_in();
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    step();
    step();
    vecs++; if (bus.pc !== 12'h000) begin errs++; $display("FAIL reset_pc got %h want 000", bus.pc); end
    vecs++; if (bus.vec_idx !== 16'h0) begin errs++; $display("FAIL reset_vec_idx got %h want 0", bus.vec_idx); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vecs++; if (bus.halted !== 1'b0) begin errs++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    vecs++; if (bus.stack_err !== 1'b0) begin errs++; $display("FAIL reset_stack_err got %b want 0", bus.stack_err); end
    vecs++; if (bus.retire !== 1'b0) begin errs++; $display("FAIL reset_retire got %b want 0", bus.retire); end
    rst = 1'b0;
  endtask

  task automatic test_straight();
    logic [11:0] exp_pc;
    idle_in();
    bus.start_pc = 12'h010;
    bus.start    = 1'b1;
    step();
    idle_in();
    vecs++; if (bus.pc !== 12'h010) begin errs++; $display("FAIL start_pc got %h want 010", bus.pc); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL start_busy got %b want 1", bus.busy); end
    for (int i = 1; i <= 3; i++) begin
      bus.done_steady = 1'b1;
      #1;
      vecs++; if (bus.retire !== 1'b1) begin errs++; $display("FAIL straight_retire%0d got %b want 1", i, bus.retire); end
      step();
      exp_pc = 12'h010 + 12'(i);
      vecs++; if (bus.pc !== exp_pc) begin errs++; $display("FAIL straight_pc%0d got %h want %h", i, bus.pc, exp_pc); end
    end
    idle_in();
    #1;
    vecs++; if (bus.retire !== 1'b0) begin errs++; $display("FAIL stall_retire got %b want 0", bus.retire); end
    step();
    vecs++; if (bus.pc !== 12'h013) begin errs++; $display("FAIL stall_pc got %h want 013", bus.pc); end
  endtask

  task automatic test_vector();
    logic        ds_pat  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_idx [5] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd0};
    idle_in();
    bus.is_not_vect = 1'b0;
    bus.vec_len     = 16'd4;
    bus.done_steady = 1'b1;
    step();
    vecs++; if (bus.pc !== 12'h013) begin errs++; $display("FAIL vect_enter_pc got %h want 013", bus.pc); end
    vecs++; if (bus.vec_idx !== 16'd0) begin errs++; $display("FAIL vect_enter_idx got %0d want 0", bus.vec_idx); end
    for (int k = 0; k < 5; k++) begin
      bus.done_steady = ds_pat[k];
      #1;
      vecs++; if (bus.retire !== ds_pat[k]) begin errs++; $display("FAIL vect_retire%0d got %b want %b", k, bus.retire, ds_pat[k]); end
      step();
      vecs++; if (bus.vec_idx !== exp_idx[k]) begin errs++; $display("FAIL vect_idx%0d got %0d want %0d", k, bus.vec_idx, exp_idx[k]); end
    end
    idle_in();
    vecs++; if (bus.pc !== 12'h014) begin errs++; $display("FAIL vect_done_pc got %h want 014", bus.pc); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL vect_done_busy got %b want 1", bus.busy); end
    bus.is_not_vect = 1'b0;
    bus.vec_len     = 16'd0;
    bus.done_steady = 1'b1;
    step();
    vecs++; if (bus.pc !== 12'h014) begin errs++; $display("FAIL vlen0_enter_pc got %h want 014", bus.pc); end
    step();
    idle_in();
    vecs++; if (bus.pc !== 12'h015) begin errs++; $display("FAIL vlen0_pc got %h want 015", bus.pc); end
    vecs++; if (bus.vec_idx !== 16'd0) begin errs++; $display("FAIL vlen0_idx got %0d want 0", bus.vec_idx); end
  endtask

  task automatic test_streamout();
    idle_in();
    bus.is_not_vect = 1'b0;
    bus.vec_len     = 16'd2;
    bus.done_steady = 1'b1;
    step();
    bus.is_vstreamout = 1'b1;
    bus.supplier      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vecs++; if (bus.retire !== 1'b0) begin errs++; $display("FAIL sout_retire%0d got %b want 0", k, bus.retire); end
      step();
      vecs++; if (bus.vec_idx !== 16'd0) begin errs++; $display("FAIL sout_idx%0d got %0d want 0", k, bus.vec_idx); end
    end
    bus.supplier = 1'b1;
    #1;
    vecs++; if (bus.retire !== 1'b1) begin errs++; $display("FAIL sout_sup_retire got %b want 1", bus.retire); end
    step();
    vecs++; if (bus.vec_idx !== 16'd1) begin errs++; $display("FAIL sout_sup_idx got %0d want 1", bus.vec_idx); end
    step();
    idle_in();
    vecs++; if (bus.pc !== 12'h016) begin errs++; $display("FAIL sout_done_pc got %h want 016", bus.pc); end
    vecs++; if (bus.vec_idx !== 16'd0) begin errs++; $display("FAIL sout_done_idx got %0d want 0", bus.vec_idx); end
  endtask

  task automatic test_branch();
    logic [1:0]  br_tab  [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
    logic        neq_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [11:0] exp_tab [6] = '{12'h005, 12'h021, 12'h005, 12'h021, 12'h005, 12'h021};
    for (int k = 0; k < 6; k++) begin
      jump_to(12'h020);
      bus.done_steady = 1'b1;
      bus.br_type     = br_tab[k];
      bus.flag_neq    = neq_tab[k];
      bus.br_target   = 12'h005;
      step();
      idle_in();
      vecs++; if (bus.pc !== exp_tab[k]) begin errs++; $display("FAIL branch%0d got %h want %h", k, bus.pc, exp_tab[k]); end
    end
  endtask

  task automatic test_loop();
    logic [11:0] exp_pc;
    jump_to(12'h030);
    bus.done_steady = 1'b1;
    bus.is_loop     = 1'b1;
    bus.loop_count  = 16'd3;
    bus.br_target   = 12'h0AA;
    step();
    idle_in();
    vecs++; if (bus.pc !== 12'h031) begin errs++; $display("FAIL loop_begin_pc got %h want 031", bus.pc); end
    for (int it = 1; it <= 3; it++) begin
      scalar_step();
      vecs++; if (bus.pc !== 12'h032) begin errs++; $display("FAIL loop_body_pc%0d got %h want 032", it, bus.pc); end
      bus.done_steady = 1'b1;
      bus.is_endloop  = 1'b1;
      step();
      idle_in();
      exp_pc = (it < 3) ? 12'h031 : 12'h033;
      vecs++; if (bus.pc !== exp_pc) begin errs++; $display("FAIL loop_end_pc%0d got %h want %h", it, bus.pc, exp_pc); end
    end
    vecs++; if (bus.stack_err !== 1'b0) begin errs++; $display("FAIL loop_err got %b want 0", bus.stack_err); end
    bus.done_steady = 1'b1;
    bus.is_loop     = 1'b1;
    bus.loop_count  = 16'd0;
    bus.br_target   = 12'h040;
    step();
    idle_in();
    vecs++; if (bus.pc !== 12'h040) begin errs++; $display("FAIL loop_zero_pc got %h want 040", bus.pc); end
    for (int n = 1; n <= 5; n++) begin
      bus.done_steady = 1'b1;
      bus.is_loop     = 1'b1;
      bus.loop_count  = 16'd1;
      step();
      idle_in();
      exp_pc = 12'h040 + 12'(n);
      vecs++; if (bus.pc !== exp_pc) begin errs++; $display("FAIL nest_pc%0d got %h want %h", n, bus.pc, exp_pc); end
      vecs++; if (bus.stack_err !== (n == 5)) begin errs++; $display("FAIL nest_err%0d got %b want %b", n, bus.stack_err, (n == 5)); end
    end
    scalar_step();
    vecs++; if (bus.stack_err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b want 1", bus.stack_err); end
  endtask

  task automatic test_wrap();
    jump_to(12'hFFF);
    scalar_step();
    vecs++; if (bus.pc !== 12'h000) begin errs++; $display("FAIL wrap_pc got %h want 000", bus.pc); end
  endtask

  task automatic test_halt();
    idle_in();
    bus.done_steady = 1'b1;
    bus.is_halt     = 1'b1;
    #1;
    vecs++; if (bus.retire !== 1'b1) begin errs++; $display("FAIL halt_retire got %b want 1", bus.retire); end
    step();
    idle_in();
    vecs++; if (bus.halted !== 1'b1) begin errs++; $display("FAIL halt_halted got %b want 1", bus.halted); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL halt_busy got %b want 0", bus.busy); end
    vecs++; if (bus.pc !== 12'h000) begin errs++; $display("FAIL halt_pc got %h want 000", bus.pc); end
    bus.done_steady = 1'b1;
    #1;
    vecs++; if (bus.retire !== 1'b0) begin errs++; $display("FAIL halted_retire got %b want 0", bus.retire); end
    step();
    idle_in();
    vecs++; if (bus.pc !== 12'h000) begin errs++; $display("FAIL halted_pc got %h want 000", bus.pc); end
    bus.start_pc = 12'h100;
    bus.start    = 1'b1;
    step();
    vecs++; if (bus.halted !== 1'b0) begin errs++; $display("FAIL restart_halted got %b want 0", bus.halted); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL restart_busy got %b want 1", bus.busy); end
    vecs++; if (bus.pc !== 12'h100) begin errs++; $display("FAIL restart_pc got %h want 100", bus.pc); end
    vecs++; if (bus.stack_err !== 1'b1) begin errs++; $display("FAIL restart_err_held got %b want 1", bus.stack_err); end
    bus.start_pc = 12'h200;
    step();
    idle_in();
    vecs++; if (bus.pc !== 12'h100) begin errs++; $display("FAIL busy_start_pc got %h want 100", bus.pc); end
  endtask

  task automatic test_reset_mid_vect();
    idle_in();
    bus.is_not_vect = 1'b0;
    bus.vec_len     = 16'd8;
    bus.done_steady = 1'b1;
    step();
    step();
    step();
    vecs++; if (bus.vec_idx !== 16'd2) begin errs++; $display("FAIL midvect_idx got %0d want 2", bus.vec_idx); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_in();
    vecs++; if (bus.pc !== 12'h000) begin errs++; $display("FAIL midvect_rst_pc got %h want 000", bus.pc); end
    vecs++; if (bus.vec_idx !== 16'd0) begin errs++; $display("FAIL midvect_rst_idx got %0d want 0", bus.vec_idx); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL midvect_rst_busy got %b want 0", bus.busy); end
    vecs++; if (bus.stack_err !== 1'b0) begin errs++; $display("FAIL midvect_rst_err got %b want 0", bus.stack_err); end
  endtask

  task automatic test_start_clears_stack();
    idle_in();
    bus.start_pc = 12'h050;
    bus.start    = 1'b1;
    step();
    idle_in();
    bus.done_steady = 1'b1;
    bus.is_loop     = 1'b1;
    bus.loop_count  = 16'd2;
    step();
    idle_in();
    bus.done_steady = 1'b1;
    bus.is_halt     = 1'b1;
    step();
    idle_in();
    vecs++; if (bus.halted !== 1'b1) begin errs++; $display("FAIL clr_halted got %b want 1", bus.halted); end
    bus.start_pc = 12'h060;
    bus.start    = 1'b1;
    step();
    idle_in();
    bus.done_steady = 1'b1;
    bus.is_endloop  = 1'b1;
    step();
    idle_in();
    vecs++; if (bus.stack_err !== 1'b1) begin errs++; $display("FAIL underflow_err got %b want 1", bus.stack_err); end
    vecs++; if (bus.pc !== 12'h061) begin errs++; $display("FAIL underflow_pc got %h want 061", bus.pc); end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_straight();
    test_vector();
    test_streamout();
    test_branch();
    test_loop();
    test_wrap();
    test_halt();
    test_reset_mid_vect();
    test_start_clears_stack();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
